// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder (IDLE -> ALIGN -> ADD -> NORM), 3-cycle latency.
// Define FP_ADD_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_add_seq #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic [EXP_W+MAN_W:0]   sum,
   output logic                   valid,
   output logic                   busy,
   output logic                   ovf,
   output logic                   unf
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 4;   // hidden + mantissa + guard/round/sticky
   localparam int XW = EXP_W + 6;   // signed working exponent, wide enough for any lzc
   localparam logic signed [XW-1:0] E_MAX = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] E_ONE = XW'(1);

   typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     a_q, b_q;
   logic [SW-1:0]    big_q, small_q;
   logic [EXP_W-1:0] exp_q;
   logic             sign_q, sub_q;
   logic [SW:0]      add_q;

   // Right shift that folds every bit shifted out into the sticky position.
   function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] v, input logic [EXP_W-1:0] d);
      logic [SW-1:0] mask;
      if (int'(d) >= SW - 1) return {{(SW-1){1'b0}}, |v};
      mask = (SW'(1) << d) - SW'(1);
      return (v >> d) | {{(SW-1){1'b0}}, |(v & mask)};
   endfunction

   // NOTE: sequential state always uses non-blocking assignments so every
   // register samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: each combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ALIGN;
         ALIGN:   state_nxt = ADD;
         ADD:     state_nxt = NORM;
         NORM:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb busy = (state != IDLE);

   logic             a_big;
   logic [EXP_W-1:0] ea, eb, e_big, e_small;
   logic [SW-1:0]    sig_a, sig_b, sig_big, sig_small_sh;

   always_comb begin
      ea           = a_q[W-2 -: EXP_W];
      eb           = b_q[W-2 -: EXP_W];
      // Exponent 0 is zero whatever the mantissa holds.
      sig_a        = (ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0], 3'b000};
      sig_b        = (eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0], 3'b000};
      a_big        = (a_q[W-2:0] >= b_q[W-2:0]);
      e_big        = a_big ? ea : eb;
      e_small      = a_big ? eb : ea;
      sig_big      = a_big ? sig_a : sig_b;
      sig_small_sh = shr_sticky(a_big ? sig_b : sig_a, e_big - e_small);
   end

   logic [SW:0]           add_sum;
   int                    lzc;
   logic [SW-1:0]         norm;
   logic signed [XW-1:0]  e_norm, e_fin;
   logic                  round_up, is_zero;
   logic [MAN_W+1:0]      man_r;
   logic [MAN_W-1:0]      man_fin;
   logic [W-1:0]          sum_nxt;
   logic                  ovf_nxt, unf_nxt;

   always_comb begin
      add_sum = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
   end

   always_comb begin
      lzc = SW;
      for (int i = 0; i < SW; i++) if (add_q[i]) lzc = SW - 1 - i;
      if (add_q[SW]) begin
         norm   = {add_q[SW:2], add_q[1] | add_q[0]};
         e_norm = XW'(exp_q) + E_ONE;
      end else begin
         norm   = add_q[SW-1:0] << lzc;
         e_norm = XW'(exp_q) - XW'(lzc);
      end
      is_zero = (norm == '0);
`ifdef FP_ADD_RNE_EN
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
      round_up = 1'b0;
`endif
      man_r   = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
      // A rounding carry-out renormalises into the next binade.
      e_fin   = man_r[MAN_W+1] ? e_norm + E_ONE : e_norm;
      man_fin = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];

      sum_nxt = '0;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      if (is_zero) begin
         sum_nxt = '0;
      end else if (e_fin > E_MAX) begin
         sum_nxt = {sign_q, {(EXP_W+MAN_W){1'b1}}};
         ovf_nxt = 1'b1;
      end else if (e_fin < E_ONE) begin
         unf_nxt = 1'b1;
      end else begin
         sum_nxt = {sign_q, e_fin[EXP_W-1:0], man_fin};
      end
   end

   // NOTE: the datapath registers are reset as well, so an aborted operation
   // leaves nothing behind that a later result could pick up.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q     <= '0;
         b_q     <= '0;
         big_q   <= '0;
         small_q <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         sub_q   <= 1'b0;
         add_q   <= '0;
         sum     <= '0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
         valid   <= 1'b0;
      end else begin
         valid <= (state == NORM);
         if (state == IDLE && start) begin
            a_q <= a;
            b_q <= b;
         end
         if (state == ALIGN) begin
            big_q   <= sig_big;
            small_q <= sig_small_sh;
            exp_q   <= e_big;
            sign_q  <= a_big ? a_q[W-1] : b_q[W-1];
            sub_q   <= a_q[W-1] ^ b_q[W-1];
         end
         if (state == ADD) add_q <= add_sum;
         if (state == NORM) begin
            sum <= sum_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq (EXP_W=3, MAN_W=4) with a result scoreboard;
// expectations follow FP_ADD_RNE_EN when it is defined.
module tb_fp_add_seq;

   localparam int EXP_W = 3;
   localparam int MAN_W = 4;
   localparam int W     = 1 + EXP_W + MAN_W;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         ovf;
      logic         unf;
   } result_t;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [W-1:0] a, b, sum;
   logic         valid, busy, ovf, unf;

   result_t exp_q[$];
   int      n_cmp  = 0;
   int      n_fail = 0;

   fp_add_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .sum   (sum),
      .valid (valid),
      .busy  (busy),
      .ovf   (ovf),
      .unf   (unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every valid pulse must match the oldest outstanding expectation.
   initial begin
      result_t r;
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            check("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               check("sum", sum, r.sum);
               check("ovf", ovf, r.ovf);
               check("unf", unf, r.unf);
            end
         end
      end
   end

   // Called just after a falling edge; returns at the falling edge of the valid cycle.
   task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [W-1:0] e_sum, input logic e_ovf, input logic e_unf);
      result_t r;
      r = '{sum: e_sum, ovf: e_ovf, unf: e_unf};
      a = op_a;
      b = op_b;
      start = 1'b1;
      exp_q.push_back(r);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      check("busy_after_start", busy, 1);
      check("valid_early0", valid, 0);
      repeat (2) begin
         @(negedge clk);
         check("valid_early", valid, 0);
      end
      @(negedge clk);
      check("valid_latency", valid, 1);
      check("busy_in_valid_cycle", busy, 0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_sum", sum, 0);
      check("rst_ovf", ovf, 0);
      check("rst_unf", unf, 0);
      reset = 1'b1;
      @(negedge clk);

      do_op(8'h30, 8'h30, 8'h40, 1'b0, 1'b0);
      do_op(8'h30, 8'hB0, 8'h00, 1'b0, 1'b0);
      do_op(8'h00, 8'h45, 8'h45, 1'b0, 1'b0);
      do_op(8'hC5, 8'h00, 8'hC5, 1'b0, 1'b0);
      do_op(8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
      do_op(8'hB0, 8'h40, 8'h30, 1'b0, 1'b0);
      do_op(8'h30, 8'hC0, 8'hB0, 1'b0, 1'b0);
      do_op(8'h11, 8'h90, 8'h00, 1'b0, 1'b1);
      do_op(8'h50, 8'h11, 8'h51, 1'b0, 1'b0);
      do_op(8'h60, 8'h60, 8'h70, 1'b0, 1'b0);
      do_op(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
`ifdef FP_ADD_RNE_EN
      do_op(8'h30, 8'h23, 8'h3A, 1'b0, 1'b0);
      do_op(8'h30, 8'h1F, 8'h38, 1'b0, 1'b0);
      do_op(8'h6F, 8'h10, 8'h70, 1'b0, 1'b0);
      do_op(8'h7F, 8'h20, 8'h7F, 1'b1, 1'b0);
`else
      do_op(8'h30, 8'h23, 8'h39, 1'b0, 1'b0);
      do_op(8'h30, 8'h1F, 8'h37, 1'b0, 1'b0);
      do_op(8'h6F, 8'h10, 8'h6F, 1'b0, 1'b0);
      do_op(8'h7F, 8'h20, 8'h7F, 1'b0, 1'b0);
`endif
      do_op(8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);

      // Flags and sum hold after the valid cycle.
      @(negedge clk);
      check("hold_valid", valid, 0);
      check("hold_ovf", ovf, 1);
      check("hold_sum", sum, 8'h7F);

      // Start held for three cycles: only the first is accepted.
      a = 8'h30;
      b = 8'h30;
      start = 1'b1;
      exp_q.push_back('{sum: 8'h40, ovf: 1'b0, unf: 1'b0});
      @(negedge clk);
      a = 8'h7F;
      b = 8'h7F;
      check("busy_t0", busy, 1);
      @(negedge clk);
      check("busy_t1", busy, 1);
      check("valid_t1", valid, 0);
      @(negedge clk);
      start = 1'b0;
      check("valid_t2", valid, 0);
      @(negedge clk);
      check("valid_t3", valid, 1);
      // Start in the valid cycle is accepted back-to-back.
      do_op(8'hB0, 8'h40, 8'h30, 1'b0, 1'b0);
      do_op(8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);

      // Reset in mid-flight aborts the operation.
      a = 8'h30;
      b = 8'h30;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_sum", sum, 0);
      check("abort_valid", valid, 0);
      check("abort_ovf", ovf, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("abort_no_valid", valid, 0);
         check("abort_sum_held", sum, 0);
      end

      do_op(8'h30, 8'h30, 8'h40, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_add_seq.md
FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 3, exponent field width (2..8).
REQ-002 The block SHALL have parameter MAN_W, default 4, stored mantissa width, hidden 1 implied (2..23); W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-006 The block SHALL have ports a, b  input  W  operands {sign, biased exponent, mantissa}.
REQ-007 The block SHALL have port sum  output  W  registered result, held until the next result.
REQ-008 The block SHALL have port valid  output  1  one-cycle pulse marking a new sum.
REQ-009 The block SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 The block SHALL have ports ovf, unf  output  1 each  overflow/underflow flags, registered with sum.

Function
REQ-011 Format SHALL use bias 2^(EXP_W-1)-1; exponent 0 SHALL mean zero regardless of mantissa (no subnormals); all-ones exponent SHALL be an ordinary finite value (no Inf/NaN).
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM; transitions IDLE->ALIGN on start=1, ALIGN->ADD, ADD->NORM, NORM->IDLE unconditionally.
REQ-013 In IDLE with start=1, a and b SHALL be captured on that edge; operands changing afterwards SHALL not affect the result.
REQ-014 ALIGN SHALL order operands by magnitude and right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits; shifts >= MAN_W+3 SHALL leave only sticky.
REQ-015 ADD SHALL add significands when signs match and subtract smaller from larger otherwise; result sign SHALL be the larger-magnitude sign.
REQ-016 NORM SHALL normalise (one right shift on carry, or left shift by leading-zero count), round, then register sum, ovf, unf and assert valid.
REQ-017 Latency SHALL be 3 cycles: start sampled at edge N, valid high for exactly the cycle after edge N+3.
REQ-018 busy SHALL be high in ALIGN, ADD and NORM, and low in IDLE.
REQ-019 start while busy=1 SHALL be ignored with no queuing; start in the cycle valid is high SHALL be accepted, giving one result per 4 cycles.
REQ-020 A zero operand SHALL yield the other operand unchanged; two zeros SHALL yield all-zero.
REQ-021 Exact cancellation SHALL yield all-zero (+0) with ovf=0 and unf=0.
REQ-022 Normalised exponent > 2^EXP_W-1 SHALL saturate sum to the max magnitude of the result sign, with ovf=1.
REQ-023 Normalised exponent < 1 SHALL flush sum to all-zero, with unf=1.
REQ-024 ovf and unf SHALL update only with valid and hold otherwise.

Reset
REQ-025 reset=0 SHALL immediately force IDLE and set sum, valid, busy, ovf, unf and all captured operands to 0.
REQ-026 Reset during ALIGN, ADD or NORM SHALL abort the operation: no valid pulse is produced and sum stays 0.
REQ-027 After reset release, the first rising edge with start=1 SHALL begin a new operation normally.

Configuration
REQ-028 Macro FP_ADD_RNE_EN defined: NORM SHALL round to nearest, ties to even, using guard/round/sticky; a mantissa carry-out SHALL increment the exponent, then the overflow check SHALL apply.
REQ-029 FP_ADD_RNE_EN undefined: NORM SHALL truncate (round toward zero), and guard/round/sticky logic MAY be omitted.

Verification (EXP_W=3, MAN_W=4)
REQ-030 a=8'h30, b=8'h30, start pulse -> valid 3 cycles later, sum=8'h40, ovf=0, unf=0.
REQ-031 a=8'h30, b=8'hB0 -> sum=8'h00, ovf=0, unf=0; a=8'h00, b=8'h45 -> sum=8'h45.
REQ-032 a=8'h7F, b=8'h7F -> sum=8'h7F, ovf=1; a=8'h11, b=8'h90 -> sum=8'h00, unf=1.
REQ-033 a=8'h30, b=8'h23 -> sum=8'h3A with FP_ADD_RNE_EN, sum=8'h39 without.
REQ-034 start on 3 consecutive cycles -> exactly one valid; start again in the valid cycle -> second valid 4 cycles after the first.
REQ-035 start, then reset=0 one cycle later -> busy=0 and sum=0 immediately, with no valid pulse before the next start.
